// File: rtl/pll_lock_sequencer_if.sv
// PLL-side and status signals of the PLL lock sequencer.
// master = sequencer, slave = PLL / downstream logic.
interface pll_lock_sequencer_if #(
    parameter int MAX_RETRIES = 3
);
    localparam int RW = $clog2(MAX_RETRIES + 1);

    logic          PLL_LOCK;
    logic          RESTART;
    logic          PLL_RESETB;
    logic          PLL_BYPASS;
    logic          SYS_RESETN;
    logic          LOCKED;
    logic          FAULT;
    logic [RW-1:0] RETRY_CNT;

    modport master (
        input  PLL_LOCK, RESTART,
        output PLL_RESETB, PLL_BYPASS, SYS_RESETN,
        output LOCKED, FAULT, RETRY_CNT
    );

    modport slave (
        output PLL_LOCK, RESTART,
        input  PLL_RESETB, PLL_BYPASS, SYS_RESETN,
        input  LOCKED, FAULT, RETRY_CNT
    );
endinterface

// File: rtl/pll_lock_sequencer.sv
// Holds the PLL in reset, waits for stable lock with timeout and retries,
// then releases system reset; falls back to bypass when lock never comes.
module pll_lock_sequencer #(
    parameter int RST_HOLD_CYCLES    = 16,
    parameter int LOCK_TIMEOUT       = 4096,
    parameter int LOCK_STABLE_CYCLES = 256,
    parameter int MAX_RETRIES        = 3
) (
    input logic                   REFERENCECLK,
    input logic                   RESET,
    pll_lock_sequencer_if.master  pll
);
    localparam int HW = $clog2(RST_HOLD_CYCLES + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int RW = $clog2(MAX_RETRIES + 1);

    localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD_CYCLES - 1);
    localparam logic [TW-1:0] TMR_LAST  = TW'(LOCK_TIMEOUT - 1);
    localparam logic [SW-1:0] STB_LAST  = SW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_HOLD, S_WAIT, S_STABLE, S_RUN, S_FAULT
    } state_t;

    state_t        state, state_n;
    logic [HW-1:0] hold_cnt, hold_n;
    logic [TW-1:0] tmr, tmr_n, tmr_inc;
    logic [SW-1:0] stb_cnt, stb_n;
    logic [RW-1:0] retry, retry_n;
    logic          lock_m, lock_s;
    logic          resetb_q, bypass_q, sysrstn_q, locked_q, fault_q;

    // PLL_LOCK is asynchronous to REFERENCECLK
    always_ff @(posedge REFERENCECLK or negedge RESET) begin
        if (!RESET) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= pll.PLL_LOCK;
            lock_s <= lock_m;
        end
    end

    assign tmr_inc = (tmr == TMR_LAST) ? tmr : tmr + 1'b1;

    always_comb begin
        state_n = state;
        hold_n  = hold_cnt;
        tmr_n   = tmr;
        stb_n   = stb_cnt;
        retry_n = retry;
        if (pll.RESTART) begin
            state_n = S_HOLD;
            hold_n  = '0;
            tmr_n   = '0;
            stb_n   = '0;
            retry_n = '0;
        end else begin
            unique case (state)
                S_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state_n = S_WAIT;
                        hold_n  = '0;
                        tmr_n   = '0;
                    end else begin
                        hold_n = hold_cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    tmr_n = tmr_inc;
                    if (lock_s) begin
                        state_n = S_STABLE;
                        stb_n   = '0;
                    end else if (tmr == TMR_LAST) begin
                        retry_n = retry + 1'b1;
                        hold_n  = '0;
                        state_n = (retry_n == RETRY_MAX) ? S_FAULT : S_HOLD;
                    end
                end
                S_STABLE: begin
                    // timer keeps running so chatter cannot extend the window
                    tmr_n = tmr_inc;
                    if (!lock_s) begin
                        state_n = S_WAIT;
                    end else if (stb_cnt == STB_LAST) begin
                        state_n = S_RUN;
                    end else begin
                        stb_n = stb_cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    if (!lock_s) begin
                        state_n = S_HOLD;
                        hold_n  = '0;
                        retry_n = '0;
                    end
                end
                S_FAULT: state_n = S_FAULT;
                default: state_n = S_HOLD;
            endcase
        end
    end

    always_ff @(posedge REFERENCECLK or negedge RESET) begin
        if (!RESET) begin
            state     <= S_HOLD;
            hold_cnt  <= '0;
            tmr       <= '0;
            stb_cnt   <= '0;
            retry     <= '0;
            resetb_q  <= 1'b0;
            bypass_q  <= 1'b0;
            sysrstn_q <= 1'b0;
            locked_q  <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state     <= state_n;
            hold_cnt  <= hold_n;
            tmr       <= tmr_n;
            stb_cnt   <= stb_n;
            retry     <= retry_n;
            resetb_q  <= state_n inside {S_WAIT, S_STABLE, S_RUN};
            bypass_q  <= state_n == S_FAULT;
            sysrstn_q <= state_n inside {S_RUN, S_FAULT};
            locked_q  <= state_n == S_RUN;
            fault_q   <= state_n == S_FAULT;
        end
    end

    assign pll.PLL_RESETB = resetb_q;
    assign pll.PLL_BYPASS = bypass_q;
    assign pll.SYS_RESETN = sysrstn_q;
    assign pll.LOCKED     = locked_q;
    assign pll.FAULT      = fault_q;
    assign pll.RETRY_CNT  = retry;
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with shortened timing parameters.
// Edge numbers are counted from a marker reset before each scenario.
module tb_pll_lock_sequencer;
    localparam int RH = 4;
    localparam int LT = 32;
    localparam int LS = 8;
    localparam int MR = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic persist;

    always #5 clk = ~clk;

    pll_lock_sequencer_if #(.MAX_RETRIES(MR)) bus ();

    pll_lock_sequencer #(
        .RST_HOLD_CYCLES(RH),
        .LOCK_TIMEOUT(LT),
        .LOCK_STABLE_CYCLES(LS),
        .MAX_RETRIES(MR)
    ) dut (
        .REFERENCECLK(clk),
        .RESET(rst_n),
        .pll(bus)
    );

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic go(int n);
        while (cyc < n) step();
    endtask

    task automatic chk_idle(string tag);
        chk({tag, "_resetb"}, 32'(bus.PLL_RESETB), 0);
        chk({tag, "_bypass"}, 32'(bus.PLL_BYPASS), 0);
        chk({tag, "_sysrstn"}, 32'(bus.SYS_RESETN), 0);
        chk({tag, "_locked"}, 32'(bus.LOCKED), 0);
        chk({tag, "_fault"}, 32'(bus.FAULT), 0);
        chk({tag, "_retry"}, 32'(bus.RETRY_CNT), 0);
    endtask

    initial begin
        bus.PLL_LOCK = 1'b0;
        bus.RESTART  = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_idle("rst");

        // normal lock
        rst_n = 1'b1;
        cyc = 0;
        go(3);  chk("nl_hold", 32'(bus.PLL_RESETB), 0);
        go(4);  chk("nl_rel", 32'(bus.PLL_RESETB), 1);
        go(9);  bus.PLL_LOCK = 1'b1;
        go(19); chk("nl_pre", 32'(bus.SYS_RESETN), 0);
        chk("nl_pre_lk", 32'(bus.LOCKED), 0);
        go(20); chk("nl_run", 32'(bus.SYS_RESETN), 1);
        chk("nl_lk", 32'(bus.LOCKED), 1);
        chk("nl_retry", 32'(bus.RETRY_CNT), 0);

        // lock loss in RUN, then relock
        bus.PLL_LOCK = 1'b0;
        cyc = 0;
        go(2); chk("ll_pre", 32'(bus.SYS_RESETN), 1);
        go(3); chk("ll_sys", 32'(bus.SYS_RESETN), 0);
        chk("ll_lk", 32'(bus.LOCKED), 0);
        chk("ll_rb", 32'(bus.PLL_RESETB), 0);
        chk("ll_retry", 32'(bus.RETRY_CNT), 0);
        bus.PLL_LOCK = 1'b1;
        go(6);  chk("ll_hold", 32'(bus.PLL_RESETB), 0);
        go(7);  chk("ll_rel", 32'(bus.PLL_RESETB), 1);
        go(15); chk("ll_pre2", 32'(bus.SYS_RESETN), 0);
        go(16); chk("ll_run", 32'(bus.LOCKED), 1);

        // RESTART from RUN, then async RESET mid-STABLE
        bus.RESTART = 1'b1;
        cyc = 0;
        go(1);
        bus.RESTART = 1'b0;
        chk("rs_sys", 32'(bus.SYS_RESETN), 0);
        chk("rs_rb", 32'(bus.PLL_RESETB), 0);
        go(8);
        chk("st_rb", 32'(bus.PLL_RESETB), 1);
        chk("st_sys", 32'(bus.SYS_RESETN), 0);
        #2;
        rst_n = 1'b0;
        bus.PLL_LOCK = 1'b0;
        #1;
        chk_idle("arst");

        // retry, then success
        step();
        step();
        rst_n = 1'b1;
        cyc = 0;
        go(35); chk("rt_win", 32'(bus.PLL_RESETB), 1);
        chk("rt_r0", 32'(bus.RETRY_CNT), 0);
        go(36); chk("rt_fail", 32'(bus.PLL_RESETB), 0);
        chk("rt_r1", 32'(bus.RETRY_CNT), 1);
        go(39); chk("rt_hold", 32'(bus.PLL_RESETB), 0);
        go(40); chk("rt_rel", 32'(bus.PLL_RESETB), 1);
        go(43); bus.PLL_LOCK = 1'b1;
        go(53); chk("rt_pre", 32'(bus.SYS_RESETN), 0);
        go(54); chk("rt_run", 32'(bus.LOCKED), 1);
        chk("rt_sys", 32'(bus.SYS_RESETN), 1);
        chk("rt_rcnt", 32'(bus.RETRY_CNT), 1);
        chk("rt_flt", 32'(bus.FAULT), 0);

        // chatter: high 5, low 1, high
        bus.RESTART = 1'b1;
        bus.PLL_LOCK = 1'b0;
        cyc = 0;
        go(1);
        bus.RESTART = 1'b0;
        chk("ch_retry", 32'(bus.RETRY_CNT), 0);
        go(5);  bus.PLL_LOCK = 1'b1;
        go(10); bus.PLL_LOCK = 1'b0;
        go(11); bus.PLL_LOCK = 1'b1;
        go(13); chk("ch_wait", 32'(bus.PLL_RESETB), 1);
        go(21); chk("ch_pre", 32'(bus.SYS_RESETN), 0);
        chk("ch_pre_lk", 32'(bus.LOCKED), 0);
        go(22); chk("ch_run", 32'(bus.LOCKED), 1);

        // chatter late in the window: dropout must not restart the timer
        bus.RESTART = 1'b1;
        bus.PLL_LOCK = 1'b0;
        cyc = 0;
        go(1);
        bus.RESTART = 1'b0;
        go(28); bus.PLL_LOCK = 1'b1;
        go(33); bus.PLL_LOCK = 1'b0;
        go(36); bus.PLL_LOCK = 1'b1;
        chk("lc_win", 32'(bus.PLL_RESETB), 1);
        chk("lc_r0", 32'(bus.RETRY_CNT), 0);
        go(37); chk("lc_fail", 32'(bus.PLL_RESETB), 0);
        chk("lc_r1", 32'(bus.RETRY_CNT), 1);
        go(49); chk("lc_pre", 32'(bus.SYS_RESETN), 0);
        go(50); chk("lc_run", 32'(bus.LOCKED), 1);

        // fault fallback
        bus.RESTART = 1'b1;
        bus.PLL_LOCK = 1'b0;
        cyc = 0;
        go(1);
        bus.RESTART = 1'b0;
        go(72); chk("ft_pre", 32'(bus.FAULT), 0);
        chk("ft_pre_rb", 32'(bus.PLL_RESETB), 1);
        chk("ft_pre_r", 32'(bus.RETRY_CNT), 1);
        go(73); chk("ft_flt", 32'(bus.FAULT), 1);
        chk("ft_byp", 32'(bus.PLL_BYPASS), 1);
        chk("ft_rb", 32'(bus.PLL_RESETB), 0);
        chk("ft_sys", 32'(bus.SYS_RESETN), 1);
        chk("ft_lk", 32'(bus.LOCKED), 0);
        chk("ft_r2", 32'(bus.RETRY_CNT), 2);
        persist = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (!(bus.FAULT && bus.PLL_BYPASS && !bus.PLL_RESETB &&
                  bus.SYS_RESETN && !bus.LOCKED && bus.RETRY_CNT == 2))
                persist = 1'b0;
        end
        chk("ft_persist", 32'(persist), 1);

        // RESTART in FAULT
        bus.RESTART = 1'b1;
        cyc = 0;
        go(1);
        bus.RESTART = 1'b0;
        chk_idle("rf");
        go(4); chk("rf_hold", 32'(bus.PLL_RESETB), 0);
        go(5); chk("rf_rel", 32'(bus.PLL_RESETB), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
